// File: rtl/ether_mac_tx_param.sv
// MII nibble transmitter: preamble/SFD, buffered payload zero-padded to MIN_WORDS, CRC-32 FCS, inter-frame gap.
// Latency: first o_tx_en cycle is one clock after the send-request rising edge; buffer words are sampled one cycle after their address.
// Backpressure: none; the buffer must keep pace, requests outside IDLE are dropped, i_abort truncates the frame into the gap.
module ether_mac_tx_param #(
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 10,
  parameter int MIN_WORDS = 30,
  parameter int IFG_NIB   = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_send_irq,
  input  logic [LEN_W-1:0]  i_length,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_data,
  output logic [LEN_W-1:0]  o_data_addr,
  output logic              o_tx_en,
  output logic [3:0]        o_txd,
  output logic              o_busy,
  output logic              o_send_done,
  output logic              o_abort_err,
  output logic              o_renew_pkg
);

  localparam int NPW   = DATA_W / 4;
  localparam int NIB_W = $clog2(NPW);
  localparam int CNT_W = $clog2(((IFG_NIB > 16) ? IFG_NIB : 16) + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] FCS  = 3'd3;
  localparam logic [2:0] IFG  = 3'd4;

  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // Each register holds what is on the wire right now; the *_nx values are
  // what the next edge will register alongside the state move.
  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [NIB_W-1:0] nib, nib_nx;
  logic [LEN_W-1:0] word_idx, word_nx;
  logic [LEN_W-1:0] eff_len, eff_nx;
  logic [LEN_W-1:0] raw_len, raw_nx;
  logic [LEN_W-1:0] addr_nx;
  logic [31:0]      sr, sr_nx;
  logic [31:0]      crc, crc_nx;
  logic             tx_en_nx;
  logic [3:0]       txd_nx;
  logic             done_nx;
  logic             abort_nx;

  // Request edge detection; armed blocks a request held high through reset
  // from looking like a fresh edge once reset is released.
  logic irq_d;
  logic armed;
  logic rise;

  // Word-load helpers shared by the PRE->DATA and word-to-word transitions.
  logic             load;
  logic [LEN_W-1:0] ld_idx;
  logic [31:0]      ld_word;
  logic [31:0]      fcs_word;

  assign rise = i_send_irq & ~irq_d & armed;

  // Reflected CRC-32 advanced by one nibble, least-significant bit first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    nib_nx   = nib;
    word_nx  = word_idx;
    eff_nx   = eff_len;
    raw_nx   = raw_len;
    addr_nx  = o_data_addr;
    sr_nx    = sr;
    crc_nx   = crc;
    tx_en_nx = 1'b0;
    txd_nx   = 4'h0;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    load     = 1'b0;
    ld_idx   = '0;
    ld_word  = '0;
    fcs_word = ~crc;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = PRE;
          cnt_nx   = '0;
          eff_nx   = (i_length < LEN_W'(MIN_WORDS)) ? LEN_W'(MIN_WORDS) : i_length;
          raw_nx   = i_length;
          addr_nx  = '0;
          crc_nx   = CRC_INIT;
          tx_en_nx = 1'b1;
          txd_nx   = 4'h5;
        end
      end

      PRE: begin
        if (cnt == CNT_W'(15)) begin
          state_nx = DATA;
          load     = 1'b1;
          ld_idx   = '0;
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
          tx_en_nx = 1'b1;
          txd_nx   = (cnt == CNT_W'(14)) ? 4'hD : 4'h5;
        end
      end

      DATA: begin
        if (nib == NIB_W'(NPW - 1)) begin
          if (word_idx == eff_len - LEN_W'(1)) begin
            // CRC already covers the nibble on the wire now.
            state_nx = FCS;
            cnt_nx   = '0;
            tx_en_nx = 1'b1;
            txd_nx   = fcs_word[3:0];
            sr_nx    = fcs_word >> 4;
          end else begin
            load   = 1'b1;
            ld_idx = word_idx + LEN_W'(1);
          end
        end else begin
          nib_nx   = nib + NIB_W'(1);
          tx_en_nx = 1'b1;
          txd_nx   = sr[3:0];
          sr_nx    = sr >> 4;
          crc_nx   = crc_nib(crc, sr[3:0]);
        end
      end

      FCS: begin
        if (cnt == CNT_W'(7)) begin
          state_nx = IFG;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
          tx_en_nx = 1'b1;
          txd_nx   = sr[3:0];
          sr_nx    = sr >> 4;
        end
      end

      IFG: begin
        if (cnt == CNT_W'(IFG_NIB - 1)) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Start of a word: sample the buffer, emit its low nibble, move the
    // address on (clamped so it never runs past the last word).
    if (load) begin
      word_nx  = ld_idx;
      nib_nx   = '0;
      if (ld_idx < raw_len) begin
        ld_word[DATA_W-1:0] = i_data;
      end
      tx_en_nx = 1'b1;
      txd_nx   = ld_word[3:0];
      sr_nx    = ld_word >> 4;
      crc_nx   = crc_nib(crc, ld_word[3:0]);
      addr_nx  = ((ld_idx + LEN_W'(1)) < eff_len) ? (ld_idx + LEN_W'(1)) : (eff_len - LEN_W'(1));
    end

    // Abort overrides whatever the active states planned.
    if (i_abort && ((state == PRE) || (state == DATA) || (state == FCS))) begin
      state_nx = IFG;
      cnt_nx   = '0;
      tx_en_nx = 1'b0;
      txd_nx   = 4'h0;
      done_nx  = 1'b0;
      abort_nx = 1'b1;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      nib         <= '0;
      word_idx    <= '0;
      eff_len     <= '0;
      raw_len     <= '0;
      sr          <= '0;
      crc         <= CRC_INIT;
      irq_d       <= 1'b0;
      armed       <= 1'b0;
      o_data_addr <= '0;
      o_tx_en     <= 1'b0;
      o_txd       <= 4'h0;
      o_busy      <= 1'b0;
      o_send_done <= 1'b0;
      o_abort_err <= 1'b0;
      o_renew_pkg <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      nib         <= nib_nx;
      word_idx    <= word_nx;
      eff_len     <= eff_nx;
      raw_len     <= raw_nx;
      sr          <= sr_nx;
      crc         <= crc_nx;
      irq_d       <= i_send_irq;
      armed       <= armed | ~i_send_irq;
      o_data_addr <= addr_nx;
      o_tx_en     <= tx_en_nx;
      o_txd       <= txd_nx;
      o_busy      <= (state_nx != IDLE);
      o_send_done <= done_nx;
      o_abort_err <= abort_nx;
      o_renew_pkg <= (state == IDLE);
    end
  end

endmodule

// File: tb/tb_ether_mac_tx_param.sv
// Randomized bench for ether_mac_tx_param: expected nibble streams from a byte-level Ethernet model feed a scoreboard.
// Latency: monitor samples every falling edge; expected data is queued before each request is raised.
// Backpressure: none; buffer model answers with one cycle of read latency.
module tb_ether_mac_tx_param;

  localparam int DW    = 16;
  localparam int LW    = 10;
  localparam int MINW  = 30;
  localparam int IFG   = 24;
  localparam int NPW   = DW / 4;
  localparam logic [31:0] POLY = 32'hEDB8_8320;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_send_irq;
  logic [LW-1:0] i_length;
  logic          i_abort;
  logic [DW-1:0] i_data;
  logic [LW-1:0] o_data_addr;
  logic          o_tx_en;
  logic [3:0]    o_txd;
  logic          o_busy;
  logic          o_send_done;
  logic          o_abort_err;
  logic          o_renew_pkg;

  ether_mac_tx_param #(.DATA_W(DW), .LEN_W(LW), .MIN_WORDS(MINW), .IFG_NIB(IFG)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_send_irq(i_send_irq), .i_length(i_length),
    .i_abort(i_abort), .i_data(i_data), .o_data_addr(o_data_addr), .o_tx_en(o_tx_en),
    .o_txd(o_txd), .o_busy(o_busy), .o_send_done(o_send_done), .o_abort_err(o_abort_err),
    .o_renew_pkg(o_renew_pkg)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<LW)-1];
  logic [3:0]    exp_q[$];
  int            exp_ev_q[$];   // 1 = normal completion, 2 = abort
  bit            mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fill_mem();
    for (int a = 0; a < (1 << LW); a++) mem[a] = DW'($urandom);
  endtask

  function automatic int eff_of(input int len);
    return (len < MINW) ? MINW : len;
  endfunction

  // Whole frame as seen on the wire: preamble, SFD, bytes low-nibble first,
  // then the complemented Ethernet CRC of those bytes. keep<0 keeps all.
  task automatic push_frame(input int len, input int keep);
    logic [3:0]    nibs[$];
    logic [31:0]   c;
    logic [DW-1:0] w;
    logic [7:0]    b;
    int            n;
    for (int i = 0; i < 15; i++) nibs.push_back(4'h5);
    nibs.push_back(4'hD);
    c = 32'hFFFF_FFFF;
    for (int a = 0; a < eff_of(len); a++) begin
      w = (a < len) ? mem[a] : '0;
      for (int k = 0; k < DW / 8; k++) begin
        b = w[8*k +: 8];
        nibs.push_back(b[3:0]);
        nibs.push_back(b[7:4]);
        c = c ^ {24'h0, b};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
    end
    c = ~c;
    for (int k = 0; k < 8; k++) nibs.push_back(c[4*k +: 4]);
    n = (keep < 0) ? nibs.size() : keep;
    for (int i = 0; i < n; i++) exp_q.push_back(nibs[i]);
    exp_ev_q.push_back((keep < 0) ? 1 : 2);
  endtask

  // Normal frame: request pulse of 3 cycles, then wait out frame and gap.
  task automatic send(input int len);
    fill_mem();
    i_length = LW'(len);
    push_frame(len, -1);
    i_send_irq = 1'b1;
    repeat (3) @(negedge i_clk);
    i_send_irq = 1'b0;
    repeat (16 + eff_of(len) * NPW + 8 + IFG + 10) @(negedge i_clk);
  endtask

  // Buffer with one cycle of read latency.
  initial begin
    logic [LW-1:0] prev_addr;
    prev_addr = '0;
    i_data = '0;
    forever begin
      @(negedge i_clk);
      i_data = mem[prev_addr];
      prev_addr = o_data_addr;
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = r ^ {31'h0, d[i]};
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT transmits or signals an end.
  initial begin
    bit          prev_tx;
    int          nib_idx;
    int          cyc;
    int          done_cyc;
    bit          renew_arm;
    logic [31:0] rcrc;
    int          ev;
    logic [3:0]  e;
    prev_tx = 1'b0; nib_idx = 0; cyc = 0; done_cyc = 0; renew_arm = 1'b0; rcrc = '1;
    forever begin
      @(negedge i_clk);
      if (!mon_en) begin
        prev_tx = 1'b0;
        renew_arm = 1'b0;
        continue;
      end
      cyc++;
      if (o_tx_en && !prev_tx) begin
        nib_idx = 0;
        rcrc = 32'hFFFF_FFFF;
      end
      if (o_tx_en) begin
        if (exp_q.size() == 0) begin
          chk("tx_unexpected", {31'h0, o_tx_en}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("txd", {28'h0, o_txd}, {28'h0, e});
        end
        if (nib_idx >= 16) rcrc = crc_step(rcrc, o_txd);
        nib_idx++;
      end else begin
        chk("txd_idle_zero", {28'h0, o_txd}, 32'h0);
      end
      if (o_send_done) begin
        ev = (exp_ev_q.size() != 0) ? exp_ev_q.pop_front() : 0;
        chk("done_event", ev, 1);
        chk("done_after_last_fcs", {30'h0, prev_tx, o_tx_en}, 32'h2);
        chk("done_all_nibbles", exp_q.size(), 0);
        chk("crc_residue", rcrc, 32'hDEBB_20E3);
        done_cyc = cyc;
        renew_arm = 1'b1;
      end
      if (o_abort_err) begin
        ev = (exp_ev_q.size() != 0) ? exp_ev_q.pop_front() : 0;
        chk("abort_event", ev, 2);
        chk("abort_tx_drop", {30'h0, prev_tx, o_tx_en}, 32'h2);
        chk("abort_nibbles", exp_q.size(), 0);
      end
      if (renew_arm && cyc == done_cyc + IFG) chk("renew_low_in_gap", {31'h0, o_renew_pkg}, 32'h0);
      if (renew_arm && cyc == done_cyc + IFG + 1) begin
        chk("renew_after_gap", {31'h0, o_renew_pkg}, 32'h1);
        renew_arm = 1'b0;
      end
      prev_tx = o_tx_en;
    end
  end

  initial begin
    i_rst_n = 1'b0; i_send_irq = 1'b0; i_abort = 1'b0; i_length = '0;
    fill_mem();
    repeat (3) @(negedge i_clk);
    chk("rst_tx_en", {31'h0, o_tx_en}, 32'h0);
    chk("rst_txd", {28'h0, o_txd}, 32'h0);
    chk("rst_addr", {22'h0, o_data_addr}, 32'h0);
    chk("rst_busy", {31'h0, o_busy}, 32'h0);
    chk("rst_done", {31'h0, o_send_done}, 32'h0);
    chk("rst_abort", {31'h0, o_abort_err}, 32'h0);
    chk("rst_renew", {31'h0, o_renew_pkg}, 32'h0);
    i_rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("idle_renew", {31'h0, o_renew_pkg}, 32'h1);
    chk("idle_busy", {31'h0, o_busy}, 32'h0);

    send(40);
    chk("addr_hold_40", {22'h0, o_data_addr}, 32'd39);
    send(5);
    chk("addr_hold_5", {22'h0, o_data_addr}, 32'd29);
    send(0);
    send(29);
    send(30);
    send(31);
    for (int r = 0; r < 6; r++) send(int'($urandom_range(0, 70)));
    send((1 << LW) - 1);
    chk("addr_hold_max", {22'h0, o_data_addr}, 32'd1022);

    // Second rising edge in DATA must be ignored.
    fill_mem(); i_length = LW'(33); push_frame(33, -1);
    i_send_irq = 1'b1; repeat (3) @(negedge i_clk); i_send_irq = 1'b0;
    repeat (40) @(negedge i_clk);
    chk("busy_in_data", {31'h0, o_busy}, 32'h1);
    i_send_irq = 1'b1; repeat (5) @(negedge i_clk); i_send_irq = 0;
    repeat (16 + 33 * NPW + 8 + IFG + 10) @(negedge i_clk);

    // Abort while data nibble 50 is on the wire.
    fill_mem(); i_length = LW'(60); push_frame(60, 16 + 51);
    i_send_irq = 1'b1; repeat (3) @(negedge i_clk); i_send_irq = 1'b0;
    repeat (64) @(negedge i_clk);
    i_abort = 1'b1; @(negedge i_clk); i_abort = 1'b0;
    repeat (8) @(negedge i_clk);
    i_abort = 1'b1; @(negedge i_clk); i_abort = 1'b0;
    i_send_irq = 1'b1; repeat (3) @(negedge i_clk); i_send_irq = 1'b0;
    chk("busy_in_gap", {31'h0, o_busy}, 32'h1);
    repeat (30) @(negedge i_clk);
    chk("idle_after_abort", {31'h0, o_busy}, 32'h0);
    i_abort = 1'b1; @(negedge i_clk); i_abort = 1'b0;
    repeat (3) @(negedge i_clk);

    // Abort and rising edge together in IDLE: the frame goes ahead.
    fill_mem(); i_length = LW'(12); push_frame(12, -1);
    i_abort = 1'b1; i_send_irq = 1'b1; @(negedge i_clk);
    i_abort = 1'b0; repeat (2) @(negedge i_clk); i_send_irq = 1'b0;
    repeat (16 + MINW * NPW + 8 + IFG + 10) @(negedge i_clk);

    // Reset during FCS with the request held high.
    fill_mem(); i_length = LW'(40); push_frame(40, -1);
    i_send_irq = 1'b1;
    repeat (16 + 160 + 4) @(negedge i_clk);
    chk("tx_before_reset", {31'h0, o_tx_en}, 32'h1);
    mon_en = 1'b0;
    exp_q.delete();
    exp_ev_q.delete();
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_tx_en", {31'h0, o_tx_en}, 32'h0);
    chk("arst_txd", {28'h0, o_txd}, 32'h0);
    chk("arst_busy", {31'h0, o_busy}, 32'h0);
    chk("arst_addr", {22'h0, o_data_addr}, 32'h0);
    chk("arst_renew", {31'h0, o_renew_pkg}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (40) @(negedge i_clk);
    chk("held_req_no_restart", {31'h0, o_busy}, 32'h0);
    i_send_irq = 1'b0;
    @(negedge i_clk);
    send(40);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("events_drained", exp_ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
